coin_acceptor: RTL

- Front-end stage feeding the vending machine FSM's `money[2:0]` input.
- Takes three raw mechanical coin-sensor lines (quarter, half, dollar) and synchronises, debounces and edge-detects each one.
- Queues accepted coins in a small FIFO and presents each coin to the FSM as a one-cycle money code.
- Reports rejected coins and keeps a running count of accepted coins.

---
 rtl/coin_acceptor_pkg.sv | 21 ++
 rtl/coin_acceptor_if.sv | 33 +++
 rtl/coin_acceptor_debounce.sv | 52 +++++
 rtl/coin_acceptor.sv | 100 ++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// coin_pkg: shared constants and types for the coin acceptor front end.
//   MONEY_W            width of the money code presented to the vending FSM
//   MONEY_NONE..D      money codes: none, $0.25, $0.50, $1.00
//   sensor_e           index of each raw coin sensor inside the event vector
package coin_pkg;

  localparam int MONEY_W     = 3;
  localparam int NUM_SENSORS = 3;

  localparam logic [MONEY_W-1:0] MONEY_NONE = 3'b000;
  localparam logic [MONEY_W-1:0] MONEY_Q    = 3'b001;
  localparam logic [MONEY_W-1:0] MONEY_H    = 3'b010;
  localparam logic [MONEY_W-1:0] MONEY_D    = 3'b011;

  typedef enum logic [1:0] {
    SENS_Q = 2'd0,
    SENS_H = 2'd1,
    SENS_D = 2'd2
  } sensor_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: sensor inputs, downstream hold and coin-reporting outputs.
//   q_raw/h_raw/d_raw  raw asynchronous coin sensors (high while a coin passes)
//   hold               downstream busy, suppresses money output
//   money              one-cycle money code to the vending FSM
//   reject             one-cycle pulse when a coin is dropped
//   coin_count         saturating count of accepted coins
//   fifo_level         current coin queue occupancy
// slave modport is the acceptor side, master modport drives the sensors.
interface coin_acceptor_if #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) ();

  logic                         q_raw;
  logic                         h_raw;
  logic                         d_raw;
  logic                         hold;
  logic [coin_pkg::MONEY_W-1:0] money;
  logic                         reject;
  logic [CNT_W-1:0]             coin_count;
  logic [$clog2(FIFO_DEPTH):0]  fifo_level;

  modport slave (
    input  q_raw, h_raw, d_raw, hold,
    output money, reject, coin_count, fifo_level
  );

  modport master (
    output q_raw, h_raw, d_raw, hold,
    input  money, reject, coin_count, fifo_level
  );

endinterface

// File: rtl/coin_acceptor_debounce.sv
// coin_debounce: synchroniser, debounce counter and rising-edge detector for
// one mechanical coin sensor.
//   clk, rst  clock and asynchronous active-low reset
//   raw       asynchronous sensor line
//   rise      one-cycle pulse on a 0->1 change of the debounced level
// The debounced level resets to 1 so a sensor stuck high through reset must
// first be seen low for DB_CYCLES before it can produce a coin.
module coin_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // NOTE: all state flops use non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // This mismatch is the DB_CYCLES-th in a row: accept the new level.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end for the vending FSM money input.
//   clk, rst  clock and asynchronous active-low reset
//   bus       coin_acceptor_if.slave: raw sensors and hold in; money, reject,
//             coin_count and fifo_level out
// Each sensor is debounced; a single coin event is queued, simultaneous
// events are rejected as a collision, and queued coins are presented one per
// cycle on money while hold is low.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  coin_acceptor_if.slave     bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  logic [NUM_SENSORS-1:0] ev;
  logic                   push_valid;
  logic                   collision;
  logic [MONEY_W-1:0]     push_code;
  logic                   pop;
  logic                   push_ok;

  logic [MONEY_W-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            level;
  logic [MONEY_W-1:0]     money_q;
  logic                   reject_q;
  logic [CNT_W-1:0]       coin_cnt;

  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_q (
    .clk(clk), .rst(rst), .raw(bus.q_raw), .rise(ev[SENS_Q])
  );
  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_h (
    .clk(clk), .rst(rst), .raw(bus.h_raw), .rise(ev[SENS_H])
  );
  coin_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_d (
    .clk(clk), .rst(rst), .raw(bus.d_raw), .rise(ev[SENS_D])
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_code = MONEY_NONE;
    if (ev[SENS_Q])      push_code = MONEY_Q;
    else if (ev[SENS_H]) push_code = MONEY_H;
    else if (ev[SENS_D]) push_code = MONEY_D;
  end

  assign push_valid = $onehot(ev);
  assign collision  = (ev != '0) && !push_valid;

  // A full queue can still take a coin when the head leaves in the same cycle.
  assign pop     = !bus.hold && (level != '0);
  assign push_ok = push_valid && ((level < DEPTH_L) || pop);

  // NOTE: queue storage is not reset; entries are only read once the pointers
  // mark them valid, so clearing the pointers is enough.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      money_q  <= MONEY_NONE;
      reject_q <= 1'b0;
      coin_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      money_q  <= pop ? mem[rd_ptr] : MONEY_NONE;
      reject_q <= collision || (push_valid && !push_ok);

      if (push_ok && (coin_cnt != '1)) coin_cnt <= coin_cnt + 1'b1;
    end
  end

  assign bus.money      = money_q;
  assign bus.reject     = reject_q;
  assign bus.coin_count = coin_cnt;
  assign bus.fifo_level = level;

endmodule
